// File: rtl/pl_sysref_align.sv
// SYSREF qualifier/distributor: synchronises SYSREF, locks on a stable period, fans out delayed pulses.
// Define PL_SYSREF_ERR_CNT_EN to build the saturating error counter; otherwise err_count_o is 0.
module pl_sysref_align #(
    parameter int unsigned NumCh      = 4,
    parameter int unsigned DlyW       = 4,
    parameter int unsigned CntW       = 16,
    parameter int unsigned SyncStages = 2,
    parameter int unsigned LockEdges  = 4,
    parameter int unsigned Tol        = 1,
    parameter int unsigned PulseW     = 1
) (
    input  logic                    pl_clk_i,
    input  logic                    pl_resetn_i,
    input  logic                    pl_sysref_captured_i,
    input  logic                    arm_i,
    input  logic                    one_shot_i,
    input  logic [NumCh*DlyW-1:0]   ch_delay_i,
    output logic [NumCh-1:0]        user_sysref_o,
    output logic                    locked_o,
    output logic [CntW-1:0]         period_o,
    output logic [2:0]              state_o,
    output logic [7:0]              err_count_o
);

    localparam int unsigned MatchW = $clog2(LockEdges + 1);
    localparam int unsigned PwW    = $clog2(PulseW + 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSearch = 3'd1,
        StVerify = 3'd2,
        StLocked = 3'd3,
        StDone   = 3'd4
    } state_e;

    state_e                         state_q, state_d;
    logic [SyncStages-1:0]          sync_q;
    logic                           sref_q;
    logic [CntW-1:0]                cnt_q, cnt_d, period_q, period_d, diff;
    logic [MatchW-1:0]              match_q, match_d;
    logic                           seen_q, seen_d, os_q, os_d;
    logic [NumCh-1:0][DlyW-1:0]     dly_q, dly_d;
    logic [NumCh-1:0][PwW-1:0]      pw_q, pw_d;
    logic [NumCh-1:0]               wait_q, wait_d, out_q, out_d, busy;
    logic                           sref_edge, cnt_max, in_tol, fire, err_ev, err_inc;

    assign sref_edge = sync_q[SyncStages-1] & ~sref_q;
    assign cnt_max   = (cnt_q == {CntW{1'b1}});
    assign diff      = (cnt_q >= period_q) ? (cnt_q - period_q) : (period_q - cnt_q);
    assign in_tol    = (diff <= CntW'(Tol));
    assign busy      = wait_q | out_q;
    // A firing edge dropped on any busy channel counts as one error for that edge.
    assign err_inc   = err_ev | (fire & (|busy));

    always_comb begin
        cnt_d = cnt_q;
        if (sref_edge) begin
            cnt_d = CntW'(1);
        end else if (!cnt_max) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        match_d  = match_q;
        seen_d   = seen_q;
        os_d     = os_q;
        fire     = 1'b0;
        err_ev   = 1'b0;
        if (!arm_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StSearch;
                    os_d    = one_shot_i;
                    seen_d  = 1'b0;
                    match_d = '0;
                end
                StSearch: begin
                    if (sref_edge) begin
                        if (!seen_q) begin
                            seen_d = 1'b1;
                        end else begin
                            period_d = cnt_q;
                            match_d  = '0;
                            state_d  = StVerify;
                        end
                    end
                end
                StVerify: begin
                    if (sref_edge) begin
                        if (in_tol) begin
                            if (match_q == MatchW'(LockEdges - 1)) state_d = StLocked;
                            else match_d = match_q + MatchW'(1);
                        end else begin
                            period_d = cnt_q;
                            match_d  = '0;
                            err_ev   = 1'b1;
                        end
                    end else if (cnt_max) begin
                        state_d = StSearch;
                        seen_d  = 1'b0;
                        err_ev  = 1'b1;
                    end
                end
                StLocked: begin
                    if (sref_edge) begin
                        if (in_tol) begin
                            fire = 1'b1;
                            if (os_q) state_d = StDone;
                        end else begin
                            state_d = StSearch;
                            seen_d  = 1'b0;
                            err_ev  = 1'b1;
                        end
                    end else if (cnt_max) begin
                        state_d = StSearch;
                        seen_d  = 1'b0;
                        err_ev  = 1'b1;
                    end
                end
                StDone: begin
                    if (sref_edge && !in_tol) err_ev = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        dly_d  = dly_q;
        pw_d   = pw_q;
        wait_d = wait_q;
        out_d  = out_q;
        if (!arm_i) begin
            wait_d = '0;
            out_d  = '0;
        end else begin
            for (int i = 0; i < NumCh; i++) begin
                if (wait_q[i]) begin
                    if (dly_q[i] == '0) begin
                        wait_d[i] = 1'b0;
                        out_d[i]  = 1'b1;
                        pw_d[i]   = PwW'(PulseW - 1);
                    end else begin
                        dly_d[i] = dly_q[i] - DlyW'(1);
                    end
                end else if (out_q[i]) begin
                    if (pw_q[i] == '0) out_d[i] = 1'b0;
                    else pw_d[i] = pw_q[i] - PwW'(1);
                end
                if (fire && !busy[i]) begin
                    wait_d[i] = 1'b1;
                    dly_d[i]  = ch_delay_i[i*DlyW +: DlyW];
                end
            end
        end
    end

    always_ff @(posedge pl_clk_i) begin
        if (!pl_resetn_i) begin
            state_q  <= StIdle;
            sync_q   <= '0;
            sref_q   <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            match_q  <= '0;
            seen_q   <= 1'b0;
            os_q     <= 1'b0;
            dly_q    <= '0;
            pw_q     <= '0;
            wait_q   <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[SyncStages-2:0], pl_sysref_captured_i};
            sref_q   <= sync_q[SyncStages-1];
            cnt_q    <= cnt_d;
            period_q <= period_d;
            match_q  <= match_d;
            seen_q   <= seen_d;
            os_q     <= os_d;
            dly_q    <= dly_d;
            pw_q     <= pw_d;
            wait_q   <= wait_d;
            out_q    <= out_d;
        end
    end

`ifdef PL_SYSREF_ERR_CNT_EN
    logic [7:0] err_q;
    always_ff @(posedge pl_clk_i) begin
        if (!pl_resetn_i) begin
            err_q <= '0;
        end else if (err_inc && (err_q != 8'hff)) begin
            err_q <= err_q + 8'd1;
        end
    end
    assign err_count_o = err_q;
`else
    logic unused_err_inc;
    assign unused_err_inc = err_inc;
    assign err_count_o    = '0;
`endif

    assign user_sysref_o = out_q;
    assign locked_o      = (state_q == StLocked) || (state_q == StDone);
    assign period_o      = period_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pl_sysref_align.sv
// Directed bench for pl_sysref_align: lock, tolerance, relock, one-shot, timeout, overlap, reset/disarm.
module tb_pl_sysref_align;

    localparam int Win = 8;
`ifdef PL_SYSREF_ERR_CNT_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, sref;
    logic        arm_a, os_a, arm_b, os_b;
    logic [15:0] dly_a;
    logic [7:0]  dly_b;
    logic [3:0]  usr_a;
    logic [1:0]  usr_b;
    logic        lock_a, lock_b;
    logic [7:0]  per_a, per_b, err_a, err_b;
    logic [2:0]  st_a, st_b;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    pl_sysref_align #(.CntW(8)) u_dut_a (
        .pl_clk_i(clk), .pl_resetn_i(rst_n), .pl_sysref_captured_i(sref),
        .arm_i(arm_a), .one_shot_i(os_a), .ch_delay_i(dly_a),
        .user_sysref_o(usr_a), .locked_o(lock_a), .period_o(per_a),
        .state_o(st_a), .err_count_o(err_a)
    );

    pl_sysref_align #(.NumCh(2), .CntW(8), .PulseW(8)) u_dut_b (
        .pl_clk_i(clk), .pl_resetn_i(rst_n), .pl_sysref_captured_i(sref),
        .arm_i(arm_b), .one_shot_i(os_b), .ch_delay_i(dly_b),
        .user_sysref_o(usr_b), .locked_o(lock_b), .period_o(per_b),
        .state_o(st_b), .err_count_o(err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Raises SYSREF `per` cycles after the previous raise; channel i of A (delay i) is
    // expected high only after posedge 4+i of the window when the edge fires.
    task automatic sref_edge(input int per, input bit fire, input bit chk);
        logic [3:0] exp;
        repeat (per - Win) @(negedge clk);
        sref = 1'b1;
        for (int j = 1; j <= Win; j++) begin
            @(posedge clk);
            #1;
            if (j == 2) sref = 1'b0;
            exp = '0;
            for (int i = 0; i < 4; i++) if (fire && (j == 4 + i)) exp[i] = 1'b1;
            if (chk) check_eq($sformatf("pulse_j%0d", j), 32'(usr_a), 32'(exp));
        end
        @(negedge clk);
    endtask

    task automatic lock_a_seq();
        for (int k = 0; k < 6; k++) sref_edge(32, 1'b0, 1'b1);
    endtask

    initial begin
        int hi_cnt;
        rst_n = 1'b0; sref = 1'b0; arm_a = 1'b0; os_a = 1'b0; arm_b = 1'b0; os_b = 1'b0;
        dly_a = 16'h3210;
        dly_b = {4'd15, 4'd15};
        repeat (3) @(negedge clk);
        check_eq("rst_state", 32'(st_a), 32'd0);
        check_eq("rst_locked", 32'(lock_a), 32'd0);
        check_eq("rst_usr", 32'(usr_a), 32'd0);
        check_eq("rst_period", 32'(per_a), 32'd0);
        check_eq("rst_err", 32'(err_a), 32'd0);
        rst_n = 1'b1;

        // Lock on 32-cycle period; lock edge itself does not fire.
        arm_a = 1'b1;
        @(negedge clk);
        check_eq("arm_search", 32'(st_a), 32'd1);
        for (int k = 0; k < 5; k++) sref_edge(32, 1'b0, 1'b1);
        check_eq("verify_state", 32'(st_a), 32'd2);
        check_eq("verify_unlocked", 32'(lock_a), 32'd0);
        sref_edge(32, 1'b0, 1'b1);
        check_eq("lock_state", 32'(st_a), 32'd3);
        check_eq("lock_flag", 32'(lock_a), 32'd1);
        check_eq("lock_period", 32'(per_a), 32'd32);
        sref_edge(32, 1'b1, 1'b1);
        sref_edge(32, 1'b1, 1'b1);
        sref_edge(33, 1'b1, 1'b1);
        check_eq("tol_state", 32'(st_a), 32'd3);
        sref_edge(32, 1'b1, 1'b1);
        check_eq("tol_period", 32'(per_a), 32'd32);
        check_eq("tol_err", 32'(err_a), 32'd0);

        // Period jump to 40 drops lock; relock after 6 more edges.
        sref_edge(40, 1'b0, 1'b1);
        check_eq("jump_state", 32'(st_a), 32'd1);
        check_eq("jump_locked", 32'(lock_a), 32'd0);
        check_eq("jump_err", 32'(err_a), ErrEn ? 32'd1 : 32'd0);
        check_eq("jump_period", 32'(per_a), 32'd32);
        for (int k = 0; k < 5; k++) sref_edge(32, 1'b0, 1'b1);
        check_eq("relock_verify", 32'(st_a), 32'd2);
        sref_edge(32, 1'b0, 1'b1);
        check_eq("relock_state", 32'(st_a), 32'd3);
        sref_edge(32, 1'b1, 1'b1);

        // One-shot: single firing edge, then DONE; repeats after re-arm.
        arm_a = 1'b0;
        @(negedge clk);
        check_eq("disarm_state", 32'(st_a), 32'd0);
        check_eq("disarm_locked", 32'(lock_a), 32'd0);
        os_a = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            arm_a = 1'b1;
            lock_a_seq();
            sref_edge(32, 1'b1, 1'b1);
            check_eq($sformatf("os_done%0d", rep), 32'(st_a), 32'd4);
            check_eq($sformatf("os_locked%0d", rep), 32'(lock_a), 32'd1);
            sref_edge(32, 1'b0, 1'b1);
            check_eq($sformatf("os_stay%0d", rep), 32'(st_a), 32'd4);
            arm_a = 1'b0;
            @(negedge clk);
            check_eq($sformatf("os_idle%0d", rep), 32'(st_a), 32'd0);
        end
        os_a = 1'b0;

        // Timeout: input stuck low past counter saturation.
        arm_a = 1'b1;
        lock_a_seq();
        check_eq("to_prelock", 32'(st_a), 32'd3);
        hi_cnt = 0;
        repeat (260) begin
            @(negedge clk);
            if (usr_a != '0) hi_cnt++;
        end
        check_eq("to_nopulse", 32'(hi_cnt), 32'd0);
        check_eq("to_state", 32'(st_a), 32'd1);
        check_eq("to_locked", 32'(lock_a), 32'd0);
        check_eq("to_period", 32'(per_a), 32'd32);
        check_eq("to_err", 32'(err_a), ErrEn ? 32'd2 : 32'd0);
        arm_a = 1'b0;

        // Overlap on B: delay 15, width 8, period 10 -> edges 8 and 9 dropped, edge 10 fires.
        arm_b = 1'b1;
        for (int k = 0; k < 6; k++) sref_edge(10, 1'b0, 1'b0);
        check_eq("ov_lock", 32'(st_b), 32'd3);
        for (int k = 0; k < 3; k++) sref_edge(10, 1'b0, 1'b0);
        check_eq("ov_err", 32'(err_b), ErrEn ? 32'd2 : 32'd0);
        check_eq("ov_state", 32'(st_b), 32'd3);
        sref_edge(10, 1'b0, 1'b0);
        hi_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (usr_b[0]) hi_cnt++;
        end
        check_eq("ov_width", 32'(hi_cnt), 32'd8);
        check_eq("ov_err_after", 32'(err_b), ErrEn ? 32'd2 : 32'd0);
        arm_b = 1'b0;

        // Reset mid-pulse.
        arm_a = 1'b1;
        lock_a_seq();
        repeat (32 - Win) @(negedge clk);
        sref = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk);
            #1;
            if (j == 2) sref = 1'b0;
        end
        check_eq("rp_pulse", 32'(usr_a), 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rp_usr", 32'(usr_a), 32'd0);
        check_eq("rp_state", 32'(st_a), 32'd0);
        check_eq("rp_period", 32'(per_a), 32'd0);
        check_eq("rp_err", 32'(err_a), 32'd0);
        rst_n = 1'b1;
        hi_cnt = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (usr_a != '0) hi_cnt++;
        end
        check_eq("rp_late", 32'(hi_cnt), 32'd0);

        // Disarm mid-delay cancels pending channels.
        @(negedge clk);
        lock_a_seq();
        repeat (32 - Win) @(negedge clk);
        sref = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk);
            #1;
            if (j == 2) sref = 1'b0;
        end
        check_eq("da_pulse", 32'(usr_a), 32'h1);
        arm_a = 1'b0;
        @(posedge clk);
        #1;
        check_eq("da_state", 32'(st_a), 32'd0);
        check_eq("da_usr", 32'(usr_a), 32'd0);
        hi_cnt = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (usr_a != '0) hi_cnt++;
        end
        check_eq("da_late", 32'(hi_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
